cbus_sram_responder: RTL and testbench

//  CBus slave (responder) backed by an on-chip word SRAM; other end of the CBus initiators that carry dcreq/icreq.

---
 rtl/cbus_sram_responder_pkg.sv | 39 +++
 rtl/cbus_sram_responder_if.sv | 10 +
 rtl/cbus_sram_bank.sv | 26 ++
 rtl/cbus_sram_responder.sv | 125 ++++++++++++
 tb/tb_cbus_sram_responder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus types and burst-length encodings for the SRAM responder slice.
package cbus_sram_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;
  typedef logic [3:0]  cbus_len_t;
  typedef logic [1:0]  cbus_size_t;

  // Length field holds beats-1, so legal values double as wrap masks.
  localparam cbus_len_t MLEN1  = 4'd0;
  localparam cbus_len_t MLEN2  = 4'd1;
  localparam cbus_len_t MLEN4  = 4'd3;
  localparam cbus_len_t MLEN8  = 4'd7;
  localparam cbus_len_t MLEN16 = 4'd15;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    cbus_size_t size;
    logic [31:0] addr;
    strobe_t    strobe;
    word_t      data;
    cbus_len_t  len;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  function automatic cbus_len_t legal_len(input cbus_len_t len);
    case (len)
      MLEN1, MLEN2, MLEN4, MLEN8, MLEN16: return len;
      default:                            return MLEN1;
    endcase
  endfunction

endpackage

// File: rtl/cbus_sram_responder_if.sv
// CBus request/response bundle between an initiator (master) and a responder (slave).
interface cbus_sram_responder_if;
  import cbus_sram_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_sram_bank.sv
// Single-port synchronous word SRAM with byte enables; read-during-write returns old data.
module cbus_sram_bank
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [MEM_AW-1:0] addr,
  input  strobe_t           we,
  input  word_t             wdata,
  output word_t             q
);

  word_t mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (en) begin
      q <= mem[addr];
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus responder backed by a word SRAM: single/burst transfers with wrapping
// beat addresses, optional wait states and a one-cycle DONE gap after last.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  cbus_sram_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DATA, DONE} responder_state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  responder_state_t  state, state_nxt;
  logic [3:0]        beat_cnt, wait_cnt;
  logic [MEM_AW-1:0] base_idx;
  cbus_len_t         len_q;
  logic              is_write_q;

  logic [MEM_AW-1:0] win_mask, cur_idx, nxt_idx;
  logic              ram_en;
  logic [MEM_AW-1:0] ram_addr;
  strobe_t           ram_we;
  word_t             ram_wdata, ram_q;

  logic unused_req;
  assign unused_req = ^{bus.creq.size, bus.creq.addr[31:MEM_AW+2], bus.creq.addr[1:0]};

  // Critical-word-first: low index bits advance mod (len+1), upper bits stay put.
  assign win_mask = MEM_AW'(len_q);
  assign cur_idx  = (base_idx & ~win_mask) | ((base_idx + MEM_AW'(beat_cnt)) & win_mask);
  assign nxt_idx  = (base_idx & ~win_mask) | ((base_idx + MEM_AW'(beat_cnt) + MEM_AW'(1)) & win_mask);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          wait_cnt <= (bus.creq.valid && WAIT_CYCLES > 0) ? 4'd1 : 4'd0;
        end
        WAIT:    wait_cnt <= (wait_cnt == WAIT_LAST) ? 4'd0 : wait_cnt + 4'd1;
        DATA:    beat_cnt <= beat_cnt + 4'd1;
        default: begin
          beat_cnt <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Transaction attributes are only consumed outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.creq.valid) begin
      base_idx   <= bus.creq.addr[MEM_AW+1:2];
      len_q      <= legal_len(bus.creq.len);
      is_write_q <= bus.creq.is_write;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.creq.valid) state_nxt = (WAIT_CYCLES > 0) ? WAIT : DATA;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = DATA;
      DATA:    if (beat_cnt == len_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response depends only on registered state and SRAM q, never on creq.
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = cur_idx;
    ram_we    = '0;
    ram_wdata = bus.creq.data;
    bus.cresp = '0;
    case (state)
      IDLE: begin
        if (bus.creq.valid && !bus.creq.is_write) begin
          ram_en   = 1'b1;
          ram_addr = bus.creq.addr[MEM_AW+1:2];
        end
      end
      WAIT: begin
        if (!is_write_q && wait_cnt == WAIT_LAST) begin
          ram_en   = 1'b1;
          ram_addr = base_idx;
        end
      end
      DATA: begin
        bus.cresp.ready = 1'b1;
        bus.cresp.last  = (beat_cnt == len_q);
        ram_en          = 1'b1;
        if (is_write_q) begin
          ram_addr = cur_idx;
          ram_we   = bus.creq.strobe;
        end else begin
          ram_addr       = nxt_idx;
          bus.cresp.data = ram_q;
        end
      end
      default: ;
    endcase
  end

  cbus_sram_bank #(.MEM_AW(MEM_AW)) u_bank (
    .clk   (clk),
    .en    (ram_en),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: vector table on a zero-wait instance, plus
// wait-state and reset-mid-burst sequences; beats are scored from a queue.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cbus_sram_responder_if bus0();
  cbus_sram_responder_if bus2();
  cbus_req_t req0, req2;
  assign bus0.creq = req0;
  assign bus2.creq = req2;

  cbus_sram_responder #(.MEM_AW(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0));
  cbus_sram_responder #(.MEM_AW(AW), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2));

  typedef struct packed {
    logic  last;
    word_t data;
  } beat_t;

  typedef struct packed {
    logic            wr;
    logic [31:0]     addr;
    cbus_len_t       len;
    strobe_t         st;
    logic [3:0][31:0] v;
  } vec_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cbus_resp_t resp(input int d);
    return (d != 0) ? bus2.cresp : bus0.cresp;
  endfunction

  task automatic drive(input int d, input cbus_req_t q);
    if (d != 0) req2 = q;
    else        req0 = q;
  endtask

  function automatic int model_beats(input cbus_len_t len);
    case (len)
      4'd0, 4'd1, 4'd3, 4'd7, 4'd15: return int'(len) + 1;
      default:                       return 1;
    endcase
  endfunction

  function automatic vec_t mkv(input logic wr, input logic [31:0] addr, input cbus_len_t len,
                               input strobe_t st, input word_t a, input word_t b,
                               input word_t c, input word_t e);
    vec_t m;
    m.wr = wr; m.addr = addr; m.len = len; m.st = st;
    m.v = {e, c, b, a};
    return m;
  endfunction

  // vals: write data per beat for writes, expected read data per beat for reads.
  task automatic run_txn(input int d, input logic wr, input logic [31:0] addr,
                         input cbus_len_t len, input strobe_t st,
                         input logic [15:0][31:0] vals, input int lat, input string name);
    int beats, got, cyc, first, last_cyc;
    cbus_resp_t r;
    cbus_req_t q;
    beat_t b;
    beats = model_beats(len);
    for (int k = 0; k < beats; k++) begin
      b.last = (k == beats - 1);
      b.data = wr ? 32'h0 : vals[k];
      exp_q.push_back(b);
    end
    q = '0;
    q.valid = 1'b1; q.is_write = wr; q.addr = addr; q.len = len;
    q.size = 2'd2; q.strobe = st; q.data = vals[0];
    drive(d, q);
    got = 0; cyc = 0; first = -1; last_cyc = -1;
    while (got < beats && cyc < 40) begin
      @(negedge clk);
      r = resp(d);
      if (r.ready) begin
        if (first < 0) first = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          check({name, " unexpected beat"}, 64'(1), 64'(0));
        end else begin
          b = exp_q.pop_front();
          check({name, " data"}, 64'(r.data), 64'(b.data));
          check({name, " last"}, 64'(r.last), 64'(b.last));
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (got < beats) begin
        q.data = vals[got];
        drive(d, q);
      end
    end
    check({name, " beats"}, 64'(got), 64'(beats));
    check({name, " latency"}, 64'(first), 64'(lat));
    check({name, " contiguous"}, 64'(last_cyc), 64'(lat + beats - 1));
    q.valid = 1'b0;
    drive(d, q);
    @(negedge clk);
    check({name, " done gap"}, 64'(resp(d)), 64'(0));
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after 500000 time units");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    logic [15:0][31:0] tv;
    cbus_req_t q;
    int got, cyc;

    vecs[0]  = mkv(1, 32'h40,   MLEN1, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    vecs[1]  = mkv(0, 32'h40,   MLEN1, 4'h0, 32'hDEADBEEF, 0, 0, 0);
    vecs[2]  = mkv(1, 32'h100,  MLEN4, 4'hF, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[3]  = mkv(0, 32'h100,  MLEN4, 4'h0, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[4]  = mkv(1, 32'h0,    MLEN4, 4'hF, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hD0D0D0D0);
    vecs[5]  = mkv(0, 32'h8,    MLEN4, 4'h0, 32'hC0C0C0C0, 32'hD0D0D0D0, 32'hA0A0A0A0, 32'hB0B0B0B0);
    vecs[6]  = mkv(1, 32'h20,   MLEN1, 4'hF, 32'hFFFFFFFF, 0, 0, 0);
    vecs[7]  = mkv(1, 32'h20,   MLEN1, 4'b0011, 32'h12345678, 0, 0, 0);
    vecs[8]  = mkv(0, 32'h20,   MLEN1, 4'h0, 32'hFFFF5678, 0, 0, 0);
    vecs[9]  = mkv(1, 32'h104,  MLEN2, 4'h0, 32'hBAD0BAD0, 32'hBAD1BAD1, 0, 0);
    vecs[10] = mkv(0, 32'h104,  MLEN2, 4'h0, 32'h22, 32'h11, 0, 0);
    vecs[11] = mkv(0, 32'h100,  4'd2,  4'h0, 32'h11, 0, 0, 0);
    vecs[12] = mkv(0, 32'h1040, MLEN1, 4'h0, 32'hDEADBEEF, 0, 0, 0);

    resetn = 1'b0;
    req0 = '0;
    req2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset resp0", 64'(bus0.cresp), 64'(0));
    check("reset resp2", 64'(bus2.cresp), 64'(0));
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("idle resp0", 64'(bus0.cresp), 64'(0));

    for (int i = 0; i < 13; i++) begin
      tv = '0;
      tv[3:0] = vecs[i].v;
      run_txn(0, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].st, tv, 1,
              $sformatf("vec%0d", i));
    end

    // Wait states: first ready three cycles after acceptance.
    tv = '0; tv[0] = 32'h77; tv[1] = 32'h88;
    run_txn(1, 1, 32'h0, MLEN2, 4'hF, tv, 3, "wait wr");
    run_txn(1, 0, 32'h0, MLEN2, 4'h0, tv, 3, "wait rd");
    tv = '0; tv[0] = 32'h88; tv[1] = 32'h77;
    run_txn(1, 0, 32'h4, MLEN2, 4'h0, tv, 3, "wait wrap");

    // Reset in the middle of an 8-beat write.
    tv = '0;
    for (int k = 0; k < 8; k++) tv[k] = 32'h50000000 + 32'(k);
    run_txn(0, 1, 32'h200, MLEN8, 4'hF, tv, 1, "pre8");

    q = '0;
    q.valid = 1'b1; q.is_write = 1'b1; q.addr = 32'h200; q.len = MLEN8;
    q.size = 2'd2; q.strobe = 4'hF; q.data = 32'h60000000;
    drive(0, q);
    got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      @(negedge clk);
      if (bus0.cresp.ready) got++;
      @(posedge clk); #1;
      cyc++;
      q.data = 32'h60000000 + 32'(got);
      drive(0, q);
    end
    check("abort beats", 64'(got), 64'(3));
    check("abort in burst", 64'(bus0.cresp.ready), 64'(1));
    resetn = 1'b0;
    #1;
    check("abort resp", 64'(bus0.cresp), 64'(0));
    q.valid = 1'b0;
    drive(0, q);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    tv = '0;
    for (int k = 0; k < 8; k++) tv[k] = (k < 3) ? 32'h60000000 + 32'(k) : 32'h50000000 + 32'(k);
    run_txn(0, 0, 32'h200, MLEN8, 4'h0, tv, 1, "post abort");
    tv = '0; tv[0] = 32'hDEADBEEF;
    run_txn(0, 0, 32'h40, MLEN1, 4'h0, tv, 1, "post reset rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
